// File: rtl/gcd_host_sequencer.sv
// ---------------------------------------------------------------------------
// gcd_host_sequencer
//
// Host-side initiator for a subtractive GCD engine. Operand pairs arrive on a
// valid/ready stream. Each job resets the engine, because the engine parks in
// its done state after finishing. The sequencer then loads A together with
// start, loads B on the following cycle, waits for done, and returns the
// result on a valid/ready output stream.
//
// Two cases never reach the engine:
//   - If either operand is zero, the answer is known (A|B), so the engine is
//     bypassed. When both are zero the result is flagged with out_err.
//   - If the engine hangs, the wait is abandoned after TIMEOUT cycles and an
//     error result is returned. The next job's engine reset recovers it.
//
// Parameters:
//   W        operand / result width
//   TIMEOUT  maximum cycles spent waiting for done (>= 4)
//   RST_CYC  cycles gcd_rst is held at the start of each job (>= 1)
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    operand stream handshake
//   in_a, in_b           operands
//   out_valid/out_ready  result stream handshake
//   out_gcd, out_err     result, error flag (timeout or both operands zero)
//   gcd_rst              engine reset (also high while rst is high)
//   gcd_start            engine start (high only while loading A)
//   gcd_data             engine data_in (A, except B during the B load cycle)
//   gcd_done             engine done (only observed while waiting)
//   gcd_result           engine A-register value
//   busy                 a job is in flight
// ---------------------------------------------------------------------------
module gcd_host_sequencer #(
  parameter int W       = 16,
  parameter int TIMEOUT = 1024,
  parameter int RST_CYC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_gcd,
  output logic         out_err,
  output logic         gcd_rst,
  output logic         gcd_start,
  output logic [W-1:0] gcd_data,
  input  logic         gcd_done,
  input  logic [W-1:0] gcd_result,
  output logic         busy
);

  // The wait timer only has to reach TIMEOUT-1.
  localparam int TW = $clog2(TIMEOUT);
  // The engine-reset counter only has to reach RST_CYC-1.
  localparam int CW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ERST_LAST  = CW'(RST_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ERST  = 3'd1,
    LOADA = 3'd2,
    LOADB = 3'd3,
    WAIT  = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t         state;
  state_t         state_next;

  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [TW-1:0]  timer;
  logic [CW-1:0]  erst_cnt;

  logic           accept;
  logic           zero_op;
  logic           both_zero;
  logic           timer_expired;
  logic           erst_last;
  logic           result_taken;

  // Handshake and decision terms.
  assign accept        = in_valid & in_ready;
  assign zero_op       = (in_a == '0) | (in_b == '0);
  assign both_zero     = (in_a == '0) & (in_b == '0);
  assign timer_expired = (timer == TIMER_LAST);
  assign erst_last     = (erst_cnt == ERST_LAST);
  assign result_taken  = out_valid & out_ready;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = zero_op ? RESP : ERST;
        end
      end
      ERST: begin
        if (erst_last) begin
          state_next = LOADA;
        end
      end
      LOADA: state_next = LOADB;
      LOADB: state_next = WAIT;
      WAIT: begin
        // done and the terminal count can coincide. Both lead to RESP, and
        // the datapath gives priority to done.
        if (gcd_done || timer_expired) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (result_taken) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output decode (registered state and registers only, plus rst for
  // the asynchronous engine-reset and ready gating)
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state == IDLE) & ~rst;
    gcd_rst   = rst | (state == ERST);
    gcd_start = (state == LOADA);
    gcd_data  = (state == LOADB) ? b : a;
    out_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  // -------------------------------------------------------------------------
  // Datapath: latched operands, counters and result registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a        <= '0;
      b        <= '0;
      timer    <= '0;
      erst_cnt <= '0;
      out_gcd  <= '0;
      out_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a        <= in_a;
            b        <= in_b;
            erst_cnt <= '0;
            // The bypass result is ready immediately. With one operand zero,
            // the OR is simply the other operand.
            if (zero_op) begin
              out_gcd <= in_a | in_b;
              out_err <= both_zero;
            end
          end
        end
        ERST: begin
          erst_cnt <= erst_cnt + 1'b1;
        end
        LOADB: begin
          timer <= '0;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          if (gcd_done) begin
            out_gcd <= gcd_result;
            out_err <= 1'b0;
          end else if (timer_expired) begin
            out_gcd <= '0;
            out_err <= 1'b1;
          end
        end
        default: begin
          // LOADA and RESP hold every register. In RESP this keeps
          // out_gcd/out_err stable until the consumer accepts them.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_host_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for gcd_host_sequencer.
// A behavioural GCD engine sits on the engine port. Its done latency is
// programmable, and it can be made to hang. Expected results come from
// Euclid's algorithm. Expected latencies come from the cycle budget of a job:
// RST_CYC reset cycles, one cycle for each load, then the wait.
// ---------------------------------------------------------------------------
module tb_gcd_host_sequencer;

  localparam int W       = 16;
  localparam int TIMEOUT = 16;
  localparam int RST_CYC = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_gcd;
  logic         out_err;
  logic         gcd_rst;
  logic         gcd_start;
  logic [W-1:0] gcd_data;
  logic         gcd_done;
  logic [W-1:0] gcd_result;
  logic         busy;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  gcd_host_sequencer #(.W(W), .TIMEOUT(TIMEOUT), .RST_CYC(RST_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_gcd    (out_gcd),
    .out_err    (out_err),
    .gcd_rst    (gcd_rst),
    .gcd_start  (gcd_start),
    .gcd_data   (gcd_data),
    .gcd_done   (gcd_done),
    .gcd_result (gcd_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic int unsigned ref_gcd(input int unsigned x, input int unsigned y);
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Behavioural engine: A is loaded with start, and B on the next cycle.
  // done rises eng_delay cycles after the B load and then stays parked until
  // gcd_rst. A hanging engine never raises done.
  int           eng_delay = 1;
  bit           eng_hang  = 1'b0;
  logic [W-1:0] eng_a     = '0;
  logic [W-1:0] eng_b     = '0;
  logic [W-1:0] eng_res   = '0;
  logic         eng_done  = 1'b0;
  int           eng_cnt   = 0;
  int           eng_phase = 0;

  always @(posedge clk) begin
    if (gcd_rst) begin
      eng_done  <= 1'b0;
      eng_cnt   <= 0;
      eng_phase <= 0;
    end else if (gcd_start) begin
      eng_a     <= gcd_data;
      eng_phase <= 1;
    end else if (eng_phase == 1) begin
      eng_b     <= gcd_data;
      eng_phase <= 2;
      eng_cnt   <= eng_hang ? 0 : eng_delay;
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        eng_done <= 1'b1;
        eng_res  <= W'(ref_gcd(int'(eng_a), int'(eng_b)));
      end
    end
  end

  assign gcd_done   = eng_done;
  assign gcd_result = eng_res;

  // Running totals of engine-reset and start cycles.
  int rst_cycles   = 0;
  int start_cycles = 0;
  always @(negedge clk) begin
    if (gcd_rst)   rst_cycles   <= rst_cycles + 1;
    if (gcd_start) start_cycles <= start_cycles + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one job end to end and checks it against the reference model.
  task automatic do_job(input logic [W-1:0] a, input logic [W-1:0] b, input int d,
                        input bit hang, input int hold, input bit keep_valid,
                        input string tag);
    int           r0, s0, n, lat, exp_lat, exp_rst, exp_start;
    logic [W-1:0] exp_g, g_seen;
    logic         exp_e;
    bit           ok_ready, ok_stable, zero, timed_out;

    zero      = (a == 0) || (b == 0);
    timed_out = !zero && (hang || (d + 1 > TIMEOUT));
    if (zero) begin
      exp_g = a | b; exp_e = (a == 0) && (b == 0);
      exp_lat = 1; exp_rst = 0; exp_start = 0;
    end else if (timed_out) begin
      exp_g = '0; exp_e = 1'b1;
      exp_lat = RST_CYC + 3 + TIMEOUT; exp_rst = RST_CYC; exp_start = 1;
    end else begin
      exp_g = W'(ref_gcd(int'(a), int'(b))); exp_e = 1'b0;
      exp_lat = RST_CYC + 3 + (d + 1); exp_rst = RST_CYC; exp_start = 1;
    end

    eng_delay = d;
    eng_hang  = hang;
    out_ready = (hold == 0);
    r0 = rst_cycles;
    s0 = start_cycles;
    in_a = a; in_b = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_accept"}, {31'd0, in_ready}, 32'd1);
    tick();  // the handshake edge
    in_valid = keep_valid;
    in_a = W'($urandom);
    in_b = W'($urandom);

    lat = 1;
    ok_ready = 1'b1;
    while (!out_valid && lat < 200) begin
      if (in_ready) ok_ready = 1'b0;
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_gcd"}, {16'd0, out_gcd}, {16'd0, exp_g});
    chk({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_e});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);

    g_seen = out_gcd;
    ok_stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (in_ready) ok_ready = 1'b0;
      tick();
      if (!out_valid || out_gcd !== g_seen) ok_stable = 1'b0;
    end
    out_ready = 1'b1;
    if (in_ready) ok_ready = 1'b0;
    tick();  // result accepted on this edge
    chk({tag, "_hold_stable"}, {31'd0, ok_stable}, 32'd1);
    chk({tag, "_in_ready_low"}, {31'd0, ok_ready}, 32'd1);
    chk({tag, "_single_pulse"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_gcd_rst_cycles"}, rst_cycles - r0, exp_rst);
    chk({tag, "_start_cycles"}, start_cycles - s0, exp_start);
    if (!zero) begin
      chk({tag, "_eng_a"}, {16'd0, eng_a}, {16'd0, a});
      chk({tag, "_eng_b"}, {16'd0, eng_b}, {16'd0, b});
    end
    $display("job %s a=%0d b=%0d delay=%0d hang=%0d -> gcd=%0d err=%0d latency=%0d",
             tag, a, b, d, hang, g_seen, exp_e, lat);
  endtask

  initial begin
    int n;
    logic [W-1:0] ra, rb;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_gcd_rst",   {31'd0, gcd_rst},   32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_gcd_start", {31'd0, gcd_start}, 32'd0);
    chk("rst_out_gcd",   {16'd0, out_gcd},   32'd0);
    chk("rst_out_err",   {31'd0, out_err},   32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_gcd_rst",  {31'd0, gcd_rst},  32'd0);

    // Basic job
    do_job(16'd48, 16'd18, 3, 0, 0, 0, "t1");

    // Back-to-back jobs with in_valid held high
    do_job(16'd7,  16'd7,     2, 0, 0, 1, "t2a");
    do_job(16'd13, 16'd5,     4, 0, 0, 1, "t2b");
    do_job(16'd1,  16'd65535, 6, 0, 0, 0, "t2c");

    // Zero operands bypass the engine
    do_job(16'd0, 16'd9, 3, 0, 0, 0, "t3a");
    do_job(16'd0, 16'd0, 3, 0, 0, 0, "t3b");
    do_job(16'd5, 16'd0, 3, 0, 0, 0, "t3c");

    // Hung engine times out; the next job recovers. Boundary: done in the
    // last WAIT cycle still wins over the timeout.
    do_job(16'd10, 16'd4, 3,  1, 0, 0, "t4_hang");
    do_job(16'd10, 16'd4, 2,  0, 0, 0, "t4_recover");
    do_job(16'd10, 16'd4, 15, 0, 0, 0, "t4_done_last");
    do_job(16'd10, 16'd4, 14, 0, 0, 0, "t4_done_early");

    // Consumer back-pressure
    do_job(16'd48, 16'd18, 3, 0, 5, 0, "t5");

    // Reset while waiting on the engine
    eng_delay = 12; eng_hang = 1'b0;
    in_a = 16'd48; in_b = 16'd18; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("t6_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_gcd_rst",   {31'd0, gcd_rst},   32'd1);
    chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_busy",      {31'd0, busy},      32'd0);
    chk("t6_in_ready",  {31'd0, in_ready},  32'd0);
    tick();
    tick();
    chk("t6_out_valid_held", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    tick();
    chk("t6_idle_after", {31'd0, out_valid | busy}, 32'd0);
    do_job(16'd21, 16'd14, 4, 0, 0, 0, "t6_next");

    // Randomized jobs
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin ra = W'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(1, 30));
                 rb = W'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(1, 30)); end
        1: begin ra = W'($urandom_range(1, 255)); rb = W'($urandom_range(1, 255)); end
        default: begin ra = W'($urandom_range(1, 65535)); rb = W'($urandom_range(1, 65535)); end
      endcase
      do_job(ra, rb, $urandom_range(1, 15), ($urandom_range(0, 9) == 0),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), $sformatf("r%0d", i));
    end
    in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/gcd_host_sequencer.md
Name: gcd_host_sequencer

Overview:
- Host-side initiator for the subtractive GCD engine (controller plus datapath pair).
- Accepts operand pairs on a valid/ready input stream and drives the engine's serial load protocol: A with start, then B on the next cycle.
- Waits for done, captures the result, and returns it on a valid/ready output stream.
- Resets the engine between jobs, because the engine parks in its done state. Also handles the zero operands and hangs the engine cannot resolve.

Parameters:
- W, 16, operand/result width
- TIMEOUT, 1024, max cycles in WAIT before abort (≥4)
- RST_CYC, 2, cycles gcd_rst is held per job (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer can accept a pair
- in_a  in  W  operand A
- in_b  in  W  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_gcd  out  W  result
- out_err  out  1  result invalid (timeout or both operands zero)
- gcd_rst  out  1  engine reset
- gcd_start  out  1  engine start
- gcd_data  out  W  engine data_in
- gcd_done  in  1  engine done
- gcd_result  in  W  engine A-register value
- busy  out  1  job in flight (state ≠ IDLE)

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- States: IDLE, ERST, LOADA, LOADB, WAIT, RESP. Outputs are decoded from registered state and registers only.
- Reset values: state=IDLE; out_gcd=0; out_err=0; out_valid=0; gcd_start=0; timer=0; latched A and B = 0.
  - in_ready=0 and gcd_rst=1 while rst is high.
  - in_ready = (state==IDLE) & ~rst.
- IDLE:
  - Handshake in_valid&in_ready latches in_a/in_b.
  - If either operand is 0, go to RESP with out_gcd = A|B and out_err = (A==0 & B==0). The engine is untouched: no gcd_rst, no gcd_start.
  - Otherwise go to ERST.
- ERST: gcd_rst=1 for exactly RST_CYC cycles, then LOADA.
- LOADA: one cycle, gcd_start=1, gcd_data=A, then LOADB.
- LOADB: one cycle, gcd_start=0, gcd_data=B, then WAIT with timer=0.
- gcd_data = A in every state except LOADB. gcd_start is 1 only in LOADA.
- WAIT:
  - timer increments each cycle.
  - gcd_done=1 captures gcd_result into out_gcd, sets out_err=0, goes to RESP.
  - If timer==TIMEOUT-1 and gcd_done=0, set out_gcd=0 and out_err=1, go to RESP.
  - gcd_done and the timeout terminal count in the same cycle: done wins.
  - gcd_done is ignored outside WAIT.
- RESP:
  - out_valid=1; out_gcd/out_err stable until out_valid&out_ready, then IDLE the next cycle.
  - out_ready may be high in the first RESP cycle: accepted that cycle.
  - in_ready=0 throughout RESP (no overlap of jobs).
- Timeout leaves the engine in an undefined state. The next job's ERST recovers it; no extra cleanup.
- Latency (nonzero operands, out_ready=1): out_valid rises RST_CYC+3+k cycles after the input handshake, where k is the number of WAIT cycles until gcd_done.
- Zero bypass: out_valid rises 1 cycle after the handshake.
- Reset mid-operation: job is dropped, no output produced, gcd_rst asserted immediately (async), all state back to IDLE.
- in_a/in_b changes after the handshake have no effect.

Test Plan:
1. Engine model attached, pair (48,18), out_ready=1 → gcd_rst high 2 cycles, start with data=48 then data=18, out_gcd=6, out_err=0, single out_valid pulse.
2. Pairs (7,7), (13,5), (1,65535) back-to-back with in_valid held high → results 7, 1, 1 in order; in_ready low from each accept until its result is taken; gcd_rst pulses before each job.
3. (0,9) → out_gcd=9, out_err=0, 1 cycle after accept, no gcd_rst/gcd_start. (0,0) → out_gcd=0, out_err=1.
4. TIMEOUT=16, engine stub never asserts done, pair (10,4) → out_valid exactly 16 cycles after WAIT entry, out_err=1, out_gcd=0. Next job (10,4) with a working engine → 2, out_err=0.
5. Pair (48,18), out_ready low 5 cycles after out_valid → out_valid and out_gcd=6 held stable 5 cycles; accept on cycle 6, in_ready=1 the next cycle.
6. rst asserted during WAIT of pair (48,18) → immediate gcd_rst=1, out_valid=0, busy=0. After release, pair (21,14) → 7 with no stale result emitted.
